level_meter: RTL and testbench



---
 rtl/level_meter.sv | 211 +++++++++++++++++++++
 tb/tb_level_meter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_meter.sv
`timescale 1ns/1ps
// level_meter: per-channel log-scale LED bar graph with peak-hold dot,
// stepped peak decay and a held clip indicator. One update per lrck frame.
module level_meter #(
    parameter int unsigned     WIDTH        = 32,
    parameter int unsigned     NUM_LEDS     = 10,
    parameter int unsigned     HOLD_FRAMES  = 4800,
    parameter int unsigned     DECAY_FRAMES = 480,
    parameter logic [WIDTH-1:0] CLIP_LEVEL  = WIDTH'(32'h7F00_0000)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                lrck,
    input  logic [WIDTH-1:0]    data_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [3:0]          peak_level,
    output logic                clip
);

    localparam int unsigned CTR_MAX  = (HOLD_FRAMES > DECAY_FRAMES) ? HOLD_FRAMES : DECAY_FRAMES;
    localparam int unsigned CTR_W    = (CTR_MAX > 1) ? $clog2(CTR_MAX) : 1;
    localparam int unsigned SEG_BASE = WIDTH - 1 - NUM_LEDS;

    localparam logic [CTR_W-1:0] HOLD_LOAD  = CTR_W'(HOLD_FRAMES - 1);
    localparam logic [CTR_W-1:0] DECAY_LOAD = CTR_W'(DECAY_FRAMES - 1);
    localparam logic [WIDTH-1:0] MAG_MAX    = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                lrck_d_q;
    logic                strobe;
    logic                upd_q;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic [WIDTH-1:0]    neg_data;
    logic [NUM_LEDS-1:0] therm;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [3:0]          bar;
    logic [3:0]          peak_q, peak_d;
    logic [CTR_W-1:0]    hold_ctr_q, hold_ctr_d;
    logic [CTR_W-1:0]    decay_ctr_q, decay_ctr_d;
    logic [CTR_W-1:0]    clip_ctr_q, clip_ctr_d;
    logic                clip_q, clip_d;
    logic                new_peak;
    logic                clip_hit;

    // One-cycle pulse on each lrck rising edge
    assign strobe = lrck & ~lrck_d_q;

    // Stage 1: saturated magnitude of the sample captured on the strobe
    always_comb begin
        neg_data = ~data_in + WIDTH'(1);
        mag_d    = mag_q;
        if (strobe) begin
            if (!data_in[WIDTH-1]) begin
                mag_d = data_in;
            end else if (neg_data[WIDTH-1]) begin
                mag_d = MAG_MAX;
            end else begin
                mag_d = neg_data;
            end
        end
    end

    // Quantise magnitude into 6 dB segments and count the lit ones
    always_comb begin
        bar = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            therm[k] = (mag_q >= (WIDTH'(1) << (SEG_BASE + k)));
            bar      = bar + 4'(therm[k]);
        end
    end

    assign new_peak = (bar != 4'd0) && (bar >= peak_q);
    assign clip_hit = (mag_q >= CLIP_LEVEL);

    // Peak FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Peak FSM next state; HOLD is left on the frame its counter runs out
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (upd_q) begin
            if (new_peak) begin
                state_d = ST_HOLD;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (hold_ctr_q <= CTR_W'(1)) begin
                            state_d = ST_DECAY;
                        end
                    end
                    ST_DECAY: begin
                        if ((decay_ctr_q == '0) && (peak_q <= 4'd1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Peak level, counters, clip flag and LED image for the next frame
    always_comb begin
        peak_d      = peak_q;
        hold_ctr_d  = hold_ctr_q;
        decay_ctr_d = decay_ctr_q;
        clip_ctr_d  = clip_ctr_q;
        clip_d      = clip_q;
        led_d       = led_q;
        if (!enable) begin
            peak_d      = '0;
            hold_ctr_d  = '0;
            decay_ctr_d = '0;
            clip_ctr_d  = '0;
            clip_d      = 1'b0;
            led_d       = '0;
        end else if (upd_q) begin
            if (new_peak) begin
                peak_d      = bar;
                hold_ctr_d  = HOLD_LOAD;
                decay_ctr_d = '0;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        hold_ctr_d = (hold_ctr_q == '0) ? '0 : hold_ctr_q - CTR_W'(1);
                        if (hold_ctr_q <= CTR_W'(1)) begin
                            decay_ctr_d = DECAY_LOAD;
                        end
                    end
                    ST_DECAY: begin
                        if (decay_ctr_q == '0) begin
                            if (peak_q <= 4'd1) begin
                                peak_d      = '0;
                                decay_ctr_d = '0;
                            end else begin
                                peak_d      = peak_q - 4'd1;
                                decay_ctr_d = DECAY_LOAD;
                            end
                        end else begin
                            decay_ctr_d = decay_ctr_q - CTR_W'(1);
                        end
                    end
                    default: begin
                        peak_d      = '0;
                        hold_ctr_d  = '0;
                        decay_ctr_d = '0;
                    end
                endcase
            end

            // Clip retriggers a full hold; otherwise count down and expire at zero
            if (clip_hit) begin
                clip_d     = 1'b1;
                clip_ctr_d = HOLD_LOAD;
            end else if (clip_ctr_q == '0) begin
                clip_d = 1'b0;
            end else begin
                clip_ctr_d = clip_ctr_q - CTR_W'(1);
            end

            for (int k = 0; k < NUM_LEDS; k++) begin
                led_d[k] = therm[k] | (peak_d == 4'(k + 1));
            end
        end
    end

    // Datapath registers: frame strobe pipeline and meter state
    always_ff @(posedge clk) begin
        if (reset) begin
            lrck_d_q    <= 1'b0;
            upd_q       <= 1'b0;
            mag_q       <= '0;
            peak_q      <= '0;
            hold_ctr_q  <= '0;
            decay_ctr_q <= '0;
            clip_ctr_q  <= '0;
            clip_q      <= 1'b0;
            led_q       <= '0;
        end else begin
            lrck_d_q    <= lrck;
            upd_q       <= strobe;
            mag_q       <= mag_d;
            peak_q      <= peak_d;
            hold_ctr_q  <= hold_ctr_d;
            decay_ctr_q <= decay_ctr_d;
            clip_ctr_q  <= clip_ctr_d;
            clip_q      <= clip_d;
            led_q       <= led_d;
        end
    end

    assign led_out    = led_q;
    assign peak_level = peak_q;
    assign clip       = clip_q;

endmodule

// File: tb/tb_level_meter.sv
`timescale 1ns/1ps
// Testbench for level_meter: directed scenarios plus random frames against a
// frame-level reference model (peak age / clip age rather than counters).
module tb_level_meter;

    localparam int W    = 32;
    localparam int N    = 10;
    localparam int H    = 4;
    localparam int D    = 2;
    localparam int HALF = 32;
    localparam logic [31:0] CLIP_LVL = 32'h7F00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        lrck;
    logic [31:0] data_in;
    logic [9:0]  led_out;
    logic [3:0]  peak_level;
    logic        clip;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_peak;
    int         m_age;
    int         m_clip_age;
    logic [9:0] exp_led;
    logic [3:0] exp_pk;
    logic       exp_clip;

    always #5 clk = ~clk;

    level_meter #(
        .WIDTH        (W),
        .NUM_LEDS     (N),
        .HOLD_FRAMES  (H),
        .DECAY_FRAMES (D),
        .CLIP_LEVEL   (CLIP_LVL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .lrck       (lrck),
        .data_in    (data_in),
        .led_out    (led_out),
        .peak_level (peak_level),
        .clip       (clip)
    );

    function automatic longint ref_mag(input logic [31:0] d);
        longint s;
        s = longint'($signed(d));
        if (s < 0) s = -s;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        return s;
    endfunction

    function automatic int ref_bar(input longint mag);
        int b;
        b = 0;
        for (int k = 0; k < N; k++) begin
            if (mag >= (longint'(1) << (W - 1 - N + k))) b++;
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_sample();
        logic [31:0] v;
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = -v;
        if ($urandom_range(0, 3) == 0) v = 32'h0;
        if ($urandom_range(0, 19) == 0) v = 32'h8000_0000;
        return v;
    endfunction

    task automatic model_reset();
        m_peak     = 0;
        m_age      = 0;
        m_clip_age = H;
        exp_led    = '0;
        exp_pk     = '0;
        exp_clip   = 1'b0;
    endtask

    // Peak held H frames after the frame that set it, then drops one segment
    // every D frames; clip shows for H frames starting with the clipping frame.
    task automatic model_frame(input logic [31:0] d);
        longint mag;
        int     bar;
        mag = ref_mag(d);
        bar = ref_bar(mag);
        if (bar > 0 && bar >= m_peak) begin
            m_peak = bar;
            m_age  = 0;
        end else if (m_peak > 0) begin
            m_age++;
            if (m_age >= H + D - 1 && ((m_age - (H + D - 1)) % D) == 0) m_peak--;
        end
        if (mag >= longint'(CLIP_LVL)) m_clip_age = 0;
        else if (m_clip_age < H) m_clip_age++;
        exp_led = 10'((1 << bar) - 1);
        if (m_peak > 0) exp_led = exp_led | 10'(1 << (m_peak - 1));
        exp_pk   = 4'(m_peak);
        exp_clip = (m_clip_age < H);
    endtask

    // Raise lrck with sample d and wait until the stage-2 update has landed
    task automatic frame_head(input logic [31:0] d);
        data_in = d;
        lrck    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_frame(d);
    endtask

    // Finish the 64-clk frame, scrambling data_in away from the rising edge
    task automatic frame_tail();
        repeat (HALF - 2) begin
            @(negedge clk);
            data_in = $urandom;
        end
        lrck = 1'b0;
        repeat (HALF) begin
            @(negedge clk);
            data_in = $urandom;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        lrck    = 1'b0;
        data_in = 32'h4000_0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            lrck = ~lrck;
            n_checks++;
            if (led_out !== 10'h0 || peak_level !== 4'd0 || clip !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got led=%h pk=%0d clip=%b want 0/0/0", i, led_out, peak_level, clip);
            end
        end
        lrck = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        n_checks++;
        if (led_out !== 10'h0 || peak_level !== 4'd0 || clip !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got led=%h pk=%0d clip=%b want 0/0/0", led_out, peak_level, clip);
        end
    endtask

    task automatic test_full_scale();
        data_in = 32'h4000_0000;
        lrck    = 1'b1;
        @(negedge clk);
        n_checks++;
        if (led_out !== 10'h0 || peak_level !== 4'd0) begin
            n_fail++;
            $display("FAIL full_scale_latency: got led=%h pk=%0d after one edge want 0/0", led_out, peak_level);
        end
        @(negedge clk);
        model_frame(32'h4000_0000);
        n_checks++;
        if (led_out !== 10'h3FF || peak_level !== 4'd10 || clip !== 1'b0) begin
            n_fail++;
            $display("FAIL full_scale: got led=%h pk=%0d clip=%b want 3ff/10/0", led_out, peak_level, clip);
        end
        n_checks++;
        if (led_out !== exp_led || peak_level !== exp_pk || clip !== exp_clip) begin
            n_fail++;
            $display("FAIL full_scale_model: got led=%h pk=%0d clip=%b want %h/%0d/%b", led_out, peak_level, clip, exp_led, exp_pk, exp_clip);
        end
        frame_tail();
    endtask

    task automatic test_hold_decay();
        logic [9:0] tbl [12];
        tbl = '{10'h201, 10'h201, 10'h201, 10'h201, 10'h101, 10'h101,
                10'h081, 10'h081, 10'h041, 10'h041, 10'h021, 10'h021};
        for (int i = 0; i < 12; i++) begin
            frame_head(32'h0020_0000);
            n_checks++;
            if (led_out !== tbl[i] || led_out !== exp_led || peak_level !== exp_pk || clip !== exp_clip) begin
                n_fail++;
                $display("FAIL hold_decay[%0d]: got led=%h pk=%0d clip=%b want %h/%0d/%b", i, led_out, peak_level, clip, tbl[i], exp_pk, exp_clip);
            end
            frame_tail();
        end
    endtask

    task automatic test_clip();
        frame_head(32'h8000_0000);
        n_checks++;
        if (led_out !== 10'h3FF || clip !== 1'b1 || peak_level !== 4'd10) begin
            n_fail++;
            $display("FAIL clip_most_negative: got led=%h pk=%0d clip=%b want 3ff/10/1", led_out, peak_level, clip);
        end
        frame_tail();
        for (int i = 0; i < 6; i++) begin
            frame_head(32'h0);
            n_checks++;
            if (clip !== (i < 3) || led_out !== exp_led || peak_level !== exp_pk || clip !== exp_clip) begin
                n_fail++;
                $display("FAIL clip_hold[%0d]: got led=%h pk=%0d clip=%b want %h/%0d/%b", i, led_out, peak_level, clip, exp_led, exp_pk, exp_clip);
            end
            frame_tail();
        end
    endtask

    task automatic test_decay_to_idle();
        frame_head(32'h7FFF_0000);
        frame_tail();
        for (int i = 0; i < 28; i++) begin
            frame_head(32'h0);
            n_checks++;
            if (led_out !== exp_led || peak_level !== exp_pk || clip !== exp_clip) begin
                n_fail++;
                $display("FAIL decay_idle[%0d]: got led=%h pk=%0d clip=%b want %h/%0d/%b", i, led_out, peak_level, clip, exp_led, exp_pk, exp_clip);
            end
            frame_tail();
        end
        n_checks++;
        if (led_out !== 10'h0 || peak_level !== 4'd0) begin
            n_fail++;
            $display("FAIL decay_idle_end: got led=%h pk=%0d want 0/0", led_out, peak_level);
        end
    endtask

    task automatic test_enable();
        frame_head(32'h4000_0000);
        frame_tail();
        frame_head(32'h0010_0000);
        frame_tail();
        enable = 1'b0;
        @(negedge clk);
        model_reset();
        n_checks++;
        if (led_out !== 10'h0 || peak_level !== 4'd0 || clip !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop: got led=%h pk=%0d clip=%b want 0/0/0", led_out, peak_level, clip);
        end
        data_in = 32'h8000_0000;
        lrck    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (led_out !== 10'h0 || peak_level !== 4'd0 || clip !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_low_frame: got led=%h pk=%0d clip=%b want 0/0/0", led_out, peak_level, clip);
        end
        frame_tail();
        enable = 1'b1;
        frame_head(32'h0200_0000);
        n_checks++;
        if (led_out !== 10'h01F || peak_level !== 4'd5 || clip !== 1'b0 || led_out !== exp_led || peak_level !== exp_pk) begin
            n_fail++;
            $display("FAIL enable_resume: got led=%h pk=%0d clip=%b want 01f/5/0", led_out, peak_level, clip);
        end
        frame_tail();
    endtask

    task automatic test_reset_mid();
        int lens [2];
        lens = '{1, 6};
        for (int s = 0; s < 2; s++) begin
            frame_head(32'h4000_0000);
            frame_tail();
            for (int i = 0; i < lens[s]; i++) begin
                frame_head(32'h0008_0000);
                frame_tail();
            end
            reset = 1'b1;
            @(negedge clk);
            n_checks++;
            if (led_out !== 10'h0 || peak_level !== 4'd0 || clip !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got led=%h pk=%0d clip=%b want 0/0/0", s, led_out, peak_level, clip);
            end
            reset = 1'b0;
            model_reset();
            @(negedge clk);
        end
    endtask

    task automatic test_lrck_held();
        frame_head(32'h0400_0000);
        for (int p = 0; p < 5; p++) begin
            repeat (2 * HALF) begin
                @(negedge clk);
                data_in = $urandom;
            end
            n_checks++;
            if (led_out !== exp_led || peak_level !== exp_pk || clip !== exp_clip) begin
                n_fail++;
                $display("FAIL lrck_held[%0d]: got led=%h pk=%0d clip=%b want %h/%0d/%b", p, led_out, peak_level, clip, exp_led, exp_pk, exp_clip);
            end
        end
        lrck = 1'b0;
        repeat (HALF) @(negedge clk);
        frame_head(rand_sample());
        n_checks++;
        if (led_out !== exp_led || peak_level !== exp_pk || clip !== exp_clip) begin
            n_fail++;
            $display("FAIL lrck_release: got led=%h pk=%0d clip=%b want %h/%0d/%b", led_out, peak_level, clip, exp_led, exp_pk, exp_clip);
        end
        frame_tail();
        n_checks++;
        if (led_out !== exp_led || peak_level !== exp_pk || clip !== exp_clip) begin
            n_fail++;
            $display("FAIL lrck_single_update: got led=%h pk=%0d clip=%b want %h/%0d/%b", led_out, peak_level, clip, exp_led, exp_pk, exp_clip);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            frame_head(rand_sample());
            n_checks++;
            if (led_out !== exp_led || peak_level !== exp_pk || clip !== exp_clip) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got led=%h pk=%0d clip=%b want %h/%0d/%b", i, led_out, peak_level, clip, exp_led, exp_pk, exp_clip);
            end
            lrck    = 1'b0;
            data_in = $urandom;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            frame_head(rand_sample());
            n_checks++;
            if (led_out !== exp_led || peak_level !== exp_pk || clip !== exp_clip) begin
                n_fail++;
                $display("FAIL random[%0d]: got led=%h pk=%0d clip=%b want %h/%0d/%b", i, led_out, peak_level, clip, exp_led, exp_pk, exp_clip);
            end
            frame_tail();
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_scale();
        test_hold_decay();
        test_clip();
        test_decay_to_idle();
        test_enable();
        test_reset_mid();
        test_lrck_held();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
